// File: rtl/cnn_pkg.sv
// Shared types for the fully-connected runner: job FSM encoding and lane packing helpers.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_QUANT,
        S_NEXT,
        S_DONE
    } state_t;

    // LSB position of lane `lane` inside a vector of `width`-bit lanes packed lane 0 first.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/requant_q31.sv
// Two-stage Q31 requantiser: round((acc*mul)/2^(MUL_W-1)), rounding right shift, add zero point,
// saturate to DATA_W, optional clamp to [zp, relu6_max]. Never stalls, so in_ready_o is tied high.
module requant_q31 #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MUL_W   = 32,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [MUL_W-1:0]   mul_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [DATA_W-1:0]  zp_i,
    input  logic               relu6_en_i,
    input  logic [DATA_W-1:0]  relu6_max_i,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o
);
    localparam int STAGES = 2;
    localparam int PROD_W = ACC_W + MUL_W;
    localparam logic signed [PROD_W-1:0] HALF   = PROD_W'(1) <<< (MUL_W - 2);
    localparam logic signed [PROD_W-1:0] SAT_HI = (PROD_W'(1) <<< (DATA_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] SAT_LO = -(PROD_W'(1) <<< (DATA_W - 1));

    logic [STAGES-1:0]        vld_pipe;
    logic signed [PROD_W-1:0] prod_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic [DATA_W-1:0]        res_q;
    logic signed [PROD_W-1:0] rnd, t, r, v, lo, hi, sat;

    assign in_ready_o  = 1'b1;
    assign out_valid_o = vld_pipe[STAGES-1];
    assign out_data_o  = res_q;

    always_comb begin
        rnd = '0;
        if (shift_q != '0) rnd = PROD_W'(1) <<< (shift_q - 1'b1);
        t   = (prod_q + HALF) >>> (MUL_W - 1);
        r   = (t + rnd) >>> shift_q;
        v   = r + PROD_W'($signed(zp_i));
        lo  = relu6_en_i ? PROD_W'($signed(zp_i)) : SAT_LO;
        hi  = relu6_en_i ? PROD_W'($signed(relu6_max_i)) : SAT_HI;
        sat = v;
        if (v < lo)      sat = lo;
        else if (v > hi) sat = hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            prod_q   <= '0;
            shift_q  <= '0;
            res_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], in_valid_i};
            if (in_valid_i) begin
                prod_q  <= PROD_W'($signed(acc_i)) * PROD_W'($signed(mul_i));
                shift_q <= shift_i;
            end
            if (vld_pipe[0]) res_q <= DATA_W'(sat);
        end
    end

endmodule

// File: rtl/fc_par_runner.sv
// Fully-connected layer runner: buffers the input vector, accumulates LANES output channels in
// parallel, requantises them serially through one requant_q31 and tracks the argmax of the outputs.
module fc_par_runner
    import cnn_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int MUL_W     = 32,
    parameter int SHIFT_W   = 6,
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 16,
    parameter int MAX_IN_CH = 1024,
    parameter int LANES     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic [DIM_W-1:0]           cfg_in_c,
    input  logic [DIM_W-1:0]           cfg_out_c,
    input  logic [ADDR_W-1:0]          cfg_in_base,
    input  logic [ADDR_W-1:0]          cfg_out_base,
    input  logic                       cfg_relu6_en,
    input  logic [DATA_W-1:0]          cfg_relu6_max,
    output logic                       in_rd_en,
    output logic [ADDR_W-1:0]          in_rd_addr,
    input  logic [DATA_W-1:0]          in_rd_data,
    output logic                       out_wr_en,
    output logic [ADDR_W-1:0]          out_wr_addr,
    output logic [DATA_W-1:0]          out_wr_data,
    output logic [DIM_W-1:0]           fc_in_idx,
    output logic [DIM_W-1:0]           fc_out_idx,
    input  logic [LANES*DATA_W-1:0]    fc_weight,
    input  logic [LANES*MUL_W-1:0]     fc_mul,
    input  logic [LANES*ACC_W-1:0]     fc_bias_acc,
    input  logic [LANES*SHIFT_W-1:0]   fc_shift,
    input  logic [DATA_W-1:0]          fc_zp,
    output logic [DIM_W-1:0]           argmax_idx
);
    localparam int IDX_W = (MAX_IN_CH > 1) ? $clog2(MAX_IN_CH) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = LW + 1;
    localparam int DW1   = DIM_W + 1;
    localparam logic [CW-1:0]  LANES_L = CW'(LANES);
    localparam logic [DW1-1:0] LANES_D = DW1'(LANES);

    state_t                      state_q, state_d;
    logic [DIM_W-1:0]            in_c_q, out_c_q;
    logic [ADDR_W-1:0]           in_base_q, out_base_q;
    logic                        relu_en_q;
    logic [DATA_W-1:0]           relu_max_q;
    logic [DIM_W-1:0]            in_idx_q, in_idx_d, out_idx_q, out_idx_d, ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]               feed_q, feed_d, ret_q, ret_d;
    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d, mac;
    logic [DIM_W-1:0]            amax_q, amax_d;
    logic [DATA_W-1:0]           maxv_q, maxv_d;
    logic                        have_q, have_d;
    logic                        cfg_ld, cfg_bad;
    logic [DATA_W-1:0]           ibuf [MAX_IN_CH];
    logic [DATA_W-1:0]           act;
    logic [LW-1:0]               sel;
    logic [DW1-1:0]              lane_ch;
    logic                        rq_vld, rq_rdy, rq_out_vld;
    logic [DATA_W-1:0]           rq_data;

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign fc_in_idx  = in_idx_q;
    assign fc_out_idx = out_idx_q;
    assign argmax_idx = amax_q;
    assign cfg_bad    = (cfg_in_c == '0) || (cfg_out_c == '0) || (32'(cfg_in_c) > 32'(MAX_IN_CH));
    assign act        = ibuf[IDX_W'(in_idx_q)];
    assign sel        = feed_q[LW-1:0];
    assign lane_ch    = {1'b0, out_idx_q} + DW1'(ret_q);

    // Read data returns one cycle after its address, so cycle n stores element n-1.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && ld_cnt_q != '0) ibuf[IDX_W'(ld_cnt_q - 1'b1)] <= in_rd_data;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]    base;
        assign prod   = $signed(act) * $signed(fc_weight[lane_lo(k, DATA_W) +: DATA_W]);
        assign base   = (in_idx_q == '0) ? $signed(fc_bias_acc[lane_lo(k, ACC_W) +: ACC_W])
                                         : $signed(acc_q[k]);
        assign mac[k] = base + ACC_W'(prod);
    end

    requant_q31 #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_W(MUL_W), .SHIFT_W(SHIFT_W)
    ) u_rq (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (rq_vld),
        .in_ready_o (rq_rdy),
        .acc_i      (acc_q[sel]),
        .mul_i      (fc_mul[lane_lo(int'(sel), MUL_W) +: MUL_W]),
        .shift_i    (fc_shift[lane_lo(int'(sel), SHIFT_W) +: SHIFT_W]),
        .zp_i       (fc_zp),
        .relu6_en_i (relu_en_q),
        .relu6_max_i(relu_max_q),
        .out_valid_o(rq_out_vld),
        .out_data_o (rq_data)
    );

    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        out_idx_d   = out_idx_q;
        ld_cnt_d    = ld_cnt_q;
        feed_d      = feed_q;
        ret_d       = ret_q;
        acc_d       = acc_q;
        amax_d      = amax_q;
        maxv_d      = maxv_q;
        have_d      = have_q;
        cfg_ld      = 1'b0;
        rq_vld      = 1'b0;
        in_rd_en    = 1'b0;
        in_rd_addr  = '0;
        out_wr_en   = 1'b0;
        out_wr_addr = '0;
        out_wr_data = '0;
        case (state_q)
            S_IDLE: if (start) begin
                cfg_ld    = 1'b1;
                amax_d    = '0;
                have_d    = 1'b0;
                out_idx_d = '0;
                in_idx_d  = '0;
                ld_cnt_d  = '0;
                state_d   = cfg_bad ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (ld_cnt_q < in_c_q) begin
                    in_rd_en   = 1'b1;
                    in_rd_addr = in_base_q + ADDR_W'(ld_cnt_q);
                end
                ld_cnt_d = ld_cnt_q + 1'b1;
                if (ld_cnt_q == in_c_q) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                acc_d = mac;
                if (in_idx_q == in_c_q - 1'b1) begin
                    in_idx_d = '0;
                    feed_d   = '0;
                    ret_d    = '0;
                    state_d  = S_QUANT;
                end else begin
                    in_idx_d = in_idx_q + 1'b1;
                end
            end
            S_QUANT: begin
                rq_vld = (feed_q < LANES_L);
                if (rq_vld && rq_rdy) feed_d = feed_q + 1'b1;
                if (rq_out_vld) begin
                    // Lanes past the last output channel are quantised but dropped.
                    if (lane_ch < {1'b0, out_c_q}) begin
                        out_wr_en   = 1'b1;
                        out_wr_addr = out_base_q + ADDR_W'(out_idx_q) + ADDR_W'(ret_q);
                        out_wr_data = rq_data;
                        if (!have_q || $signed(rq_data) > $signed(maxv_q)) begin
                            have_d = 1'b1;
                            maxv_d = rq_data;
                            amax_d = DIM_W'(lane_ch);
                        end
                    end
                    ret_d = ret_q + 1'b1;
                    if (ret_q == LANES_L - 1'b1) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if ({1'b0, out_idx_q} + LANES_D >= {1'b0, out_c_q}) begin
                    state_d = S_DONE;
                end else begin
                    out_idx_d = out_idx_q + DIM_W'(LANES);
                    state_d   = S_ACCUM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            ld_cnt_q   <= '0;
            feed_q     <= '0;
            ret_q      <= '0;
            acc_q      <= '0;
            amax_q     <= '0;
            maxv_q     <= '0;
            have_q     <= 1'b0;
            in_c_q     <= '0;
            out_c_q    <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            relu_en_q  <= 1'b0;
            relu_max_q <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            ld_cnt_q  <= ld_cnt_d;
            feed_q    <= feed_d;
            ret_q     <= ret_d;
            acc_q     <= acc_d;
            amax_q    <= amax_d;
            maxv_q    <= maxv_d;
            have_q    <= have_d;
            if (cfg_ld) begin
                in_c_q     <= cfg_in_c;
                out_c_q    <= cfg_out_c;
                in_base_q  <= cfg_in_base;
                out_base_q <= cfg_out_base;
                relu_en_q  <= cfg_relu6_en;
                relu_max_q <= cfg_relu6_max;
            end
        end
    end

endmodule

// File: tb/tb_fc_par_runner.sv
// Randomised bench for fc_par_runner: memories and weight tables live here and every job is
// checked against a plain-arithmetic model of the layer (dot product, Q31 rounding, clamps).
module tb_fc_par_runner;
    localparam int DATA_W = 8, ACC_W = 32, MUL_W = 32, SHIFT_W = 6, ADDR_W = 32, DIM_W = 16;
    localparam int MAX_IN_CH = 1024, LANES = 4;

    logic clk, rst_n, start, busy, done;
    logic [DIM_W-1:0]  cfg_in_c, cfg_out_c, fc_in_idx, fc_out_idx, argmax_idx;
    logic [ADDR_W-1:0] cfg_in_base, cfg_out_base, in_rd_addr, out_wr_addr;
    logic              cfg_relu6_en, in_rd_en, out_wr_en;
    logic [DATA_W-1:0] cfg_relu6_max, in_rd_data, out_wr_data, fc_zp;
    logic [LANES*DATA_W-1:0]  fc_weight;
    logic [LANES*MUL_W-1:0]   fc_mul;
    logic [LANES*ACC_W-1:0]   fc_bias_acc;
    logic [LANES*SHIFT_W-1:0] fc_shift;

    int W [16][16];
    int bias [16];
    int mulv [16];
    int shv [16];
    int mem [256];
    int zp_i, rmax_i;

    logic [ADDR_W-1:0] wq_addr [$];
    int                wq_data [$];
    int rd_cnt, done_cnt;
    int n_chk, n_fail;

    fc_par_runner #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_W(MUL_W), .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W),
        .DIM_W(DIM_W), .MAX_IN_CH(MAX_IN_CH), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cfg_in_c(cfg_in_c), .cfg_out_c(cfg_out_c), .cfg_in_base(cfg_in_base),
        .cfg_out_base(cfg_out_base), .cfg_relu6_en(cfg_relu6_en), .cfg_relu6_max(cfg_relu6_max),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .fc_in_idx(fc_in_idx), .fc_out_idx(fc_out_idx), .fc_weight(fc_weight), .fc_mul(fc_mul),
        .fc_bias_acc(fc_bias_acc), .fc_shift(fc_shift), .fc_zp(fc_zp), .argmax_idx(argmax_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rd_cnt   = 0;
        done_cnt = 0;
    end

    always @(posedge clk) begin
        if (in_rd_en) begin
            in_rd_data <= mem[in_rd_addr[7:0]][7:0];
            rd_cnt     <= rd_cnt + 1;
        end
        if (out_wr_en) begin
            wq_addr.push_back(out_wr_addr);
            wq_data.push_back(int'($signed(out_wr_data)));
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Parameter tables settle mid-cycle, ahead of the edge that consumes them.
    always @(negedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            fc_weight[k*DATA_W +: DATA_W]  <= 8'(W[(int'(fc_out_idx) + k) & 15][int'(fc_in_idx) & 15]);
            fc_bias_acc[k*ACC_W +: ACC_W]  <= 32'(bias[(int'(fc_out_idx) + k) & 15]);
            fc_mul[k*MUL_W +: MUL_W]       <= 32'(mulv[(int'(fc_out_idx) + k) & 15]);
            fc_shift[k*SHIFT_W +: SHIFT_W] <= 6'(shv[(int'(fc_out_idx) + k) & 15]);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Real-valued meaning: y = clamp(round_half_up(acc * mul / 2^31 / 2^sh) + zp).
    function automatic int ref_q(input int acc, input int mul, input int sh, input int zp,
                                 input bit ren, input int rmax);
        longint p, y, lo, hi;
        p = longint'(acc) * longint'(mul);
        y = (p + 64'sd1073741824) >>> 31;
        if (sh > 0) y = (y + (longint'(1) <<< (sh - 1))) >>> sh;
        y  = y + zp;
        lo = ren ? zp : -128;
        hi = ren ? rmax : 127;
        if (y < lo) y = lo;
        if (y > hi) y = hi;
        return int'(y);
    endfunction

    task automatic run_job(input string tag, input int inc, input int outc,
                           output int w0, output int lat);
        int exp_q [$];
        int rd0, dn0, am, best, acc, ib8;
        bit bad;
        w0  = wq_addr.size();
        rd0 = rd_cnt;
        dn0 = done_cnt;
        cfg_in_c  = 16'(inc);
        cfg_out_c = 16'(outc);
        fc_zp         = 8'(zp_i);
        cfg_relu6_max = 8'(rmax_i);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 4000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, done, 1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_pulses"}, done_cnt - dn0, 1);

        bad  = (inc == 0) || (outc == 0) || (inc > MAX_IN_CH);
        ib8  = int'(cfg_in_base[7:0]);
        am   = 0;
        best = -1000;
        if (!bad) begin
            for (int ch = 0; ch < outc; ch++) begin
                acc = bias[ch];
                for (int i = 0; i < inc; i++) acc += mem[(ib8 + i) & 255] * W[ch][i];
                exp_q.push_back(ref_q(acc, mulv[ch], shv[ch], zp_i, cfg_relu6_en, rmax_i));
                if (exp_q[ch] > best) begin
                    best = exp_q[ch];
                    am   = ch;
                end
            end
        end
        chk({tag, "_reads"}, rd_cnt - rd0, bad ? 0 : inc);
        chk({tag, "_nwrites"}, wq_addr.size() - w0, exp_q.size());
        chk({tag, "_argmax"}, argmax_idx, am);
        for (int i = 0; i < exp_q.size() && (w0 + i) < wq_addr.size(); i++) begin
            chk($sformatf("%s_waddr%0d", tag, i), wq_addr[w0 + i], cfg_out_base + 32'(i));
            chk($sformatf("%s_wdata%0d", tag, i), wq_data[w0 + i], exp_q[i]);
        end
    endtask

    task automatic set_uniform(input int in_val_base, input int wv, input int bv);
        for (int c = 0; c < 16; c++) begin
            bias[c] = bv;
            mulv[c] = 32'h4000_0000;
            shv[c]  = 0;
            for (int i = 0; i < 16; i++) W[c][i] = wv;
        end
        for (int i = 0; i < 16; i++) mem[(in_val_base + i) & 255] = i + 1;
    endtask

    initial begin
        int w0, lat, cyc;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_in_c = '0; cfg_out_c = '0; cfg_in_base = '0; cfg_out_base = '0;
        cfg_relu6_en = 1'b0; cfg_relu6_max = '0; fc_zp = '0;
        zp_i = 0; rmax_i = 0;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        set_uniform(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_in_idx", fc_in_idx, 0);
        chk("rst_out_idx", fc_out_idx, 0);
        chk("rst_argmax", argmax_idx, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // in=[1,2,3,4], unit weights, 0.5 scale -> 5 on every channel
        set_uniform(16, 1, 0);
        cfg_in_base  = 32'h0000_0010;
        cfg_out_base = 32'h0000_0100;
        run_job("dot4", 4, 4, w0, lat);
        for (int k = 0; k < 4; k++)
            if (w0 + k < wq_data.size()) chk($sformatf("dot4_val%0d", k), wq_data[w0 + k], 5);
        chk("dot4_argmax0", argmax_idx, 0);

        // partial last lane group
        cfg_out_base = 32'h8000_0040;
        run_job("oc6", 4, 6, w0, lat);
        chk("oc6_count", wq_addr.size() - w0, 6);

        // relu6 clamp on both sides
        set_uniform(32, 0, 0);
        mem[32] = 1;
        bias[0] = -50;
        bias[1] = 100;
        cfg_in_base  = 32'h0000_0020;
        cfg_out_base = 32'h0000_0200;
        cfg_relu6_en = 1'b1;
        rmax_i = 6;
        run_job("relu", 1, 2, w0, lat);
        if (w0 + 1 < wq_data.size()) begin
            chk("relu_lo", wq_data[w0], 0);
            chk("relu_hi", wq_data[w0 + 1], 6);
        end
        chk("relu_argmax", argmax_idx, 1);
        cfg_relu6_en = 1'b0;
        rmax_i = 0;

        // degenerate configs
        run_job("inc0", 0, 4, w0, lat);
        chk("inc0_fast", (lat <= 2) ? 1 : 0, 1);
        run_job("outc0", 3, 0, w0, lat);
        run_job("inc_big", MAX_IN_CH + 1, 4, w0, lat);

        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < 16; c++) begin
                bias[c] = int'($urandom_range(0, 4000)) - 2000;
                mulv[c] = int'($urandom_range(32'h1000_0000, 32'h7fff_ffff));
                shv[c]  = int'($urandom_range(0, 6));
                for (int i = 0; i < 16; i++) W[c][i] = int'($urandom_range(0, 255)) - 128;
            end
            zp_i   = int'($urandom_range(0, 16)) - 8;
            rmax_i = zp_i + int'($urandom_range(0, 100));
            cfg_relu6_en = 1'($urandom_range(0, 1));
            cfg_in_base  = {24'($urandom), 8'($urandom_range(0, 200))};
            cfg_out_base = 32'($urandom);
            run_job($sformatf("rnd%0d", j), int'($urandom_range(1, 12)),
                    int'($urandom_range(1, 12)), w0, lat);
        end

        // abandon a job mid-accumulation
        cfg_relu6_en = 1'b0;
        cfg_in_c  = 16'd12;
        cfg_out_c = 16'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (fc_in_idx != 16'd5 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach_accum", fc_in_idx, 5);
        w0 = wq_addr.size();
        lat = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_idx", fc_in_idx, 0);
        chk("abort_out_idx", fc_out_idx, 0);
        chk("abort_wr_en", out_wr_en, 0);
        chk("abort_rd_en", in_rd_en, 0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_writes", wq_addr.size() - w0, 0);
        chk("abort_no_done", done_cnt - lat, 0);
        chk("abort_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_par_runner.md
FC_PAR_RUNNER -- requirements
Module: fc_par_runner
Interface
REQ-001 SHALL have parameter DATA_W, default 8, activation/weight/output width (signed).
REQ-002 SHALL have parameter ACC_W, default 32, accumulator and bias width (signed).
REQ-003 SHALL have parameter MUL_W, default 32, Q31 requant multiplier width.
REQ-004 SHALL have parameter SHIFT_W, default 6, requant shift width.
REQ-005 SHALL have parameter ADDR_W, default 32, activation memory address width.
REQ-006 SHALL have parameter DIM_W, default 16, channel count/index width.
REQ-007 SHALL have parameter MAX_IN_CH, default 1024, input buffer depth.
REQ-008 SHALL have parameter LANES, default 4, output channels accumulated in parallel.
REQ-009 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port start, input, 1, launch job; sampled only in S_IDLE.
REQ-012 SHALL have port busy, output, 1, high whenever state != S_IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have ports cfg_in_c, cfg_out_c, input, DIM_W each, input/output channel counts, latched on start.
REQ-015 SHALL have ports cfg_in_base, cfg_out_base, input, ADDR_W each, activation base addresses, latched on start.
REQ-016 SHALL have port cfg_relu6_en, input, 1, clamp outputs to [zp, cfg_relu6_max] when set; latched on start.
REQ-017 SHALL have port cfg_relu6_max, input, DATA_W, ReLU6 upper bound in output quant domain; latched on start.
REQ-018 SHALL have ports in_rd_en (output 1), in_rd_addr (output ADDR_W), in_rd_data (input DATA_W): synchronous-read input memory, data valid the cycle after in_rd_en.
REQ-019 SHALL have ports out_wr_en (output 1), out_wr_addr (output ADDR_W), out_wr_data (output DATA_W): output memory write.
REQ-020 SHALL have ports fc_in_idx, fc_out_idx, output, DIM_W each: current input index and first output channel of current lane group.
REQ-021 SHALL have port fc_weight, input, LANES*DATA_W, lane k weight W[fc_out_idx+k][fc_in_idx] at bits [k*DATA_W +: DATA_W], combinational same-cycle.
REQ-022 SHALL have ports fc_mul (LANES*MUL_W), fc_bias_acc (LANES*ACC_W), fc_shift (LANES*SHIFT_W), input, per-lane packed as fc_weight, valid while fc_out_idx stable.
REQ-023 SHALL have port fc_zp, input, DATA_W, output zero point shared by all lanes.
REQ-024 SHALL have port argmax_idx, output, DIM_W, index of largest written output of last job, valid from done until next start.
Function
REQ-025 SHALL sequence S_IDLE->S_LOAD->S_ACCUM->S_QUANT->S_NEXT->(S_ACCUM | S_DONE)->S_IDLE; start while busy ignored.
REQ-026 SHALL in S_LOAD issue reads base+0..in_c-1 on consecutive cycles, storing each datum one cycle later; S_LOAD lasts in_c+1 cycles.
REQ-027 SHALL in S_ACCUM step fc_in_idx 0..in_c-1 one per cycle, lane k acc = bias_k + sum(in*w_k), full-precision product sign-extended, wrapping at ACC_W.
REQ-028 SHALL in S_QUANT feed lanes 0..LANES-1 serially into one requant_q31 (valid/ready), write each result at out_base+fc_out_idx+k when out_valid, skipping lanes with fc_out_idx+k >= out_c.
REQ-029 SHALL in S_NEXT advance fc_out_idx by LANES or go to S_DONE when fc_out_idx+LANES >= out_c; S_DONE pulses done for one cycle.
REQ-030 SHALL track argmax on writes: strictly greater replaces, ties keep lowest index; reset to 0 on start.
REQ-031 SHALL, if cfg_in_c==0, cfg_out_c==0 or cfg_in_c>MAX_IN_CH, go IDLE->S_DONE with no reads or writes, argmax_idx=0.
REQ-032 SHALL hold in_rd_en, out_wr_en low outside S_LOAD/S_QUANT; addresses and data 0 when enables low.
Reset
REQ-033 SHALL on rst_n low (any state, mid-job included) force S_IDLE, busy=done=out_wr_en=in_rd_en=0, fc_in_idx=fc_out_idx=argmax_idx=0, accumulators 0; input buffer contents need not reset; job abandoned.
Structure
REQ-034 SHALL place state_t enum and lane packing helpers in shared package cnn_pkg; sole sub-module requant_q31 (single instance, relu6 ports driven from latched cfg).
Verification
REQ-035 SHALL test in_c=4, out_c=4, LANES=4, in=[1,2,3,4], all weights 1, bias 0, mul=2^30, shift 0, zp 0 -> outputs 5,5,5,5 (10*0.5), argmax_idx=0.
REQ-036 SHALL test out_c=6, LANES=4 -> exactly 6 writes at out_base+0..5, lanes 2,3 of group 2 not written, one done pulse.
REQ-037 SHALL test relu6_en=1, max=6, zp=0, acc=-50 and +100 (mul=2^30) -> writes 0 and 6.
REQ-038 SHALL test cfg_in_c=0 -> done within 2 cycles, zero writes; then rst_n pulse mid-S_ACCUM -> busy=0 next cycle, no further writes.
